axi_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI slave port (write path and read path independently) between `NUM_M` AXI masters inside the interconnect. It watches each master's AWVALID/ARVALID as a request. It issues a registered one-hot grant that the interconnect muxes use to steer channels. It holds each grant for a full transaction: address through write response, or address through last read beat.

---
 rtl/axi_rr_arbiter_if.sv | 36 +++
 rtl/axi_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rr_arbiter_if.sv
// Arbiter bundle: per-master requests, slave completion handshakes
// and the registered write/read grants returned to the interconnect.
interface axi_rr_arbiter_if #(
   parameter int NUM_M = 4,
   parameter int ID_W  = 2
);
   logic [NUM_M-1:0] aw_req;
   logic [NUM_M-1:0] ar_req;
   logic             s_BVALID;
   logic             s_BREADY;
   logic             s_RVALID;
   logic             s_RREADY;
   logic             s_RLAST;
   logic [NUM_M-1:0] w_grant;
   logic [ID_W-1:0]  w_grant_id;
   logic             w_busy;
   logic [NUM_M-1:0] r_grant;
   logic [ID_W-1:0]  r_grant_id;
   logic             r_busy;

   modport master (
      output aw_req, ar_req,
      output s_BVALID, s_BREADY,
      output s_RVALID, s_RREADY, s_RLAST,
      input  w_grant, w_grant_id, w_busy,
      input  r_grant, r_grant_id, r_busy
   );

   modport slave (
      input  aw_req, ar_req,
      input  s_BVALID, s_BREADY,
      input  s_RVALID, s_RREADY, s_RLAST,
      output w_grant, w_grant_id, w_busy,
      output r_grant, r_grant_id, r_busy
   );
endinterface

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter sharing one AXI slave port between NUM_M
// masters; write and read paths each hold a grant per transaction.
module axi_rr_fsm #(
   parameter int NUM_M = 4,
   parameter int ID_W  = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [NUM_M-1:0] i_req,
   input  logic             i_done,
   output logic [NUM_M-1:0] o_grant,
   output logic [ID_W-1:0]  o_grant_id,
   output logic             o_busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_TURN = 2'd2;

   localparam logic [ID_W:0]   LP_NUM  = (ID_W+1)'(NUM_M);
   localparam logic [ID_W-1:0] LP_LAST = ID_W'(NUM_M - 1);

   logic [1:0]       r_state;
   logic [ID_W-1:0]  r_ptr;
   logic [NUM_M-1:0] r_grant;
   logic [ID_W-1:0]  r_id;
   logic             r_busy;

   logic             w_found;
   logic [ID_W-1:0]  w_idx;
   logic [ID_W:0]    w_cand;
   logic [ID_W-1:0]  w_next;

   // first requester at or above ptr, wrapping modulo NUM_M
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         w_cand = {1'b0, r_ptr} + (ID_W+1)'(i);
         if (w_cand >= LP_NUM) begin
            w_cand = w_cand - LP_NUM;
         end
         if (!w_found && i_req[w_cand[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_cand[ID_W-1:0];
         end
      end
   end

   // pointer advances past the winner, wrapping at NUM_M
   always_comb begin
      w_next = (w_idx == LP_LAST) ? '0 : w_idx + 1'b1;
   end

   // IDLE grants, OWN holds until completion, TURN idles one cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
         r_id    <= '0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_OWN;
                  r_ptr   <= w_next;
                  r_grant <= NUM_M'(1) << w_idx;
                  r_id    <= w_idx;
                  r_busy  <= 1'b1;
               end
            end
            S_OWN: begin
               if (i_done) begin
                  r_state <= S_TURN;
                  r_grant <= '0;
                  r_id    <= '0;
                  r_busy  <= 1'b0;
               end
            end
            S_TURN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
               r_id    <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant    = r_grant;
   assign o_grant_id = r_id;
   assign o_busy     = r_busy;
endmodule

module axi_rr_arbiter #(
   parameter int NUM_M = 4,
   parameter int ID_W  = 2
) (
   input  logic           ACLK,
   input  logic           ARESETn,
   axi_rr_arbiter_if.slave bus
);
   logic w_wdone;
   logic w_rdone;

   // transaction ends on the B handshake or the last R beat
   always_comb begin
      w_wdone = bus.s_BVALID && bus.s_BREADY;
      w_rdone = bus.s_RVALID && bus.s_RREADY && bus.s_RLAST;
   end

   axi_rr_fsm #(
      .NUM_M (NUM_M),
      .ID_W  (ID_W)
   ) u_wr (
      .i_clk      (ACLK),
      .i_rst_n    (ARESETn),
      .i_req      (bus.aw_req),
      .i_done     (w_wdone),
      .o_grant    (bus.w_grant),
      .o_grant_id (bus.w_grant_id),
      .o_busy     (bus.w_busy)
   );

   axi_rr_fsm #(
      .NUM_M (NUM_M),
      .ID_W  (ID_W)
   ) u_rd (
      .i_clk      (ACLK),
      .i_rst_n    (ARESETn),
      .i_req      (bus.ar_req),
      .i_done     (w_rdone),
      .o_grant    (bus.r_grant),
      .o_grant_id (bus.r_grant_id),
      .o_busy     (bus.r_busy)
   );
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: a 4-master instance driven from
// a write-path vector table plus sequences, and a 3-master instance.
module tb_axi_rr_arbiter;
   logic ACLK;
   logic ARESETn;

   int n_chk;
   int n_fail;

   axi_rr_arbiter_if #(.NUM_M(4), .ID_W(2)) u_if4 ();
   axi_rr_arbiter_if #(.NUM_M(3), .ID_W(2)) u_if3 ();

   axi_rr_arbiter #(.NUM_M(4), .ID_W(2)) u_dut4 (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (u_if4.slave)
   );

   axi_rr_arbiter #(.NUM_M(3), .ID_W(2)) u_dut3 (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (u_if3.slave)
   );

   typedef struct {
      logic [3:0] aw;
      logic       bh;
      logic [3:0] eg;
      int         eid;
      logic       eb;
   } vec_t;

   vec_t tbl[$];

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] aw, input logic bh,
                      input logic [3:0] eg, input int eid,
                      input logic eb);
      vec_t v;
      v.aw  = aw;
      v.bh  = bh;
      v.eg  = eg;
      v.eid = eid;
      v.eb  = eb;
      tbl.push_back(v);
   endtask

   task automatic chk_w(input string nm, input logic [3:0] g,
                        input int id, input logic b);
      chk({nm, ".w_grant"}, int'(u_if4.w_grant), int'(g));
      chk({nm, ".w_id"}, int'(u_if4.w_grant_id), id);
      chk({nm, ".w_busy"}, int'(u_if4.w_busy), int'(b));
   endtask

   task automatic chk_r(input string nm, input logic [3:0] g,
                        input int id, input logic b);
      chk({nm, ".r_grant"}, int'(u_if4.r_grant), int'(g));
      chk({nm, ".r_id"}, int'(u_if4.r_grant_id), id);
      chk({nm, ".r_busy"}, int'(u_if4.r_busy), int'(b));
   endtask

   task automatic set_b(input logic v);
      u_if4.s_BVALID = v;
      u_if4.s_BREADY = v;
   endtask

   task automatic set_r(input logic v, input logic last);
      u_if4.s_RVALID = v;
      u_if4.s_RREADY = v;
      u_if4.s_RLAST  = last;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      ARESETn = 1'b0;
      u_if4.aw_req = '0;
      u_if4.ar_req = '0;
      set_b(1'b0);
      set_r(1'b0, 1'b0);
      u_if3.aw_req   = '0;
      u_if3.ar_req   = '0;
      u_if3.s_BVALID = 1'b0;
      u_if3.s_BREADY = 1'b0;
      u_if3.s_RVALID = 1'b0;
      u_if3.s_RREADY = 1'b0;
      u_if3.s_RLAST  = 1'b0;

      // 1010 held, B three cycles after grant: 1,3,1,3
      add(4'b1010, 1'b0, 4'b0010, 1, 1'b1);
      add(4'b1010, 1'b0, 4'b0010, 1, 1'b1);
      add(4'b1010, 1'b0, 4'b0010, 1, 1'b1);
      add(4'b1010, 1'b1, 4'b0000, 0, 1'b0);
      add(4'b1010, 1'b0, 4'b0000, 0, 1'b0);
      add(4'b1010, 1'b0, 4'b1000, 3, 1'b1);
      add(4'b1010, 1'b0, 4'b1000, 3, 1'b1);
      add(4'b1010, 1'b0, 4'b1000, 3, 1'b1);
      add(4'b1010, 1'b1, 4'b0000, 0, 1'b0);
      add(4'b1010, 1'b0, 4'b0000, 0, 1'b0);
      add(4'b1010, 1'b0, 4'b0010, 1, 1'b1);
      add(4'b1010, 1'b0, 4'b0010, 1, 1'b1);
      add(4'b1010, 1'b0, 4'b0010, 1, 1'b1);
      add(4'b1010, 1'b1, 4'b0000, 0, 1'b0);
      add(4'b1010, 1'b0, 4'b0000, 0, 1'b0);
      add(4'b1010, 1'b0, 4'b1000, 3, 1'b1);
      add(4'b0000, 1'b0, 4'b1000, 3, 1'b1);
      add(4'b0000, 1'b1, 4'b0000, 0, 1'b0);
      add(4'b0000, 1'b0, 4'b0000, 0, 1'b0);
      add(4'b0000, 1'b1, 4'b0000, 0, 1'b0);
      add(4'b0000, 1'b0, 4'b0000, 0, 1'b0);

      tick();
      chk_w("rst", 4'b0000, 0, 1'b0);
      chk_r("rst", 4'b0000, 0, 1'b0);
      chk("rst3.w_grant", int'(u_if3.w_grant), 0);
      tick();
      ARESETn = 1'b1;
      tick();
      chk_w("idle", 4'b0000, 0, 1'b0);

      foreach (tbl[i]) begin
         u_if4.aw_req = tbl[i].aw;
         set_b(tbl[i].bh);
         tick();
         chk_w($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eid, tbl[i].eb);
         chk($sformatf("vec%0d.r_busy", i), int'(u_if4.r_busy), 0);
      end
      set_b(1'b0);

      // 1111 reads, 4 beats each, only RLAST releases
      u_if4.ar_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         chk_r($sformatf("rd%0d.grant", g), 4'(1 << (g % 4)), g % 4, 1'b1);
         for (int b = 0; b < 3; b++) begin
            set_r(1'b1, 1'b0);
            tick();
            chk_r($sformatf("rd%0d.beat%0d", g, b), 4'(1 << (g % 4)), g % 4, 1'b1);
         end
         set_r(1'b1, 1'b1);
         tick();
         chk_r($sformatf("rd%0d.last", g), 4'b0000, 0, 1'b0);
         set_r(1'b0, 1'b0);
         if (g == 4) u_if4.ar_req = 4'b0000;
         tick();
         chk_r($sformatf("rd%0d.turn", g), 4'b0000, 0, 1'b0);
      end

      // granted master 2 drops, master 0 raises
      u_if4.aw_req = 4'b0100;
      tick();
      chk_w("drop.grant", 4'b0100, 2, 1'b1);
      u_if4.aw_req = 4'b0001;
      tick();
      chk_w("drop.hold1", 4'b0100, 2, 1'b1);
      tick();
      chk_w("drop.hold2", 4'b0100, 2, 1'b1);
      set_b(1'b1);
      tick();
      chk_w("drop.done", 4'b0000, 0, 1'b0);
      set_b(1'b0);
      tick();
      chk_w("drop.turn", 4'b0000, 0, 1'b0);
      tick();
      chk_w("drop.next", 4'b0001, 0, 1'b1);
      u_if4.aw_req = 4'b0000;
      set_b(1'b1);
      tick();
      set_b(1'b0);
      tick();
      tick();

      // both paths owned by master 1 independently
      u_if4.aw_req = 4'b0010;
      u_if4.ar_req = 4'b0010;
      tick();
      chk_w("both.w", 4'b0010, 1, 1'b1);
      chk_r("both.r", 4'b0010, 1, 1'b1);
      u_if4.aw_req = 4'b0000;
      u_if4.ar_req = 4'b0000;
      set_r(1'b1, 1'b1);
      tick();
      set_r(1'b0, 1'b0);
      chk_r("both.rdone", 4'b0000, 0, 1'b0);
      chk_w("both.wkeep", 4'b0010, 1, 1'b1);
      tick();
      chk_w("both.wkeep2", 4'b0010, 1, 1'b1);
      set_b(1'b1);
      tick();
      set_b(1'b0);
      chk_w("both.wdone", 4'b0000, 0, 1'b0);
      tick();
      tick();

      // async reset mid-OWN, then pointer restart check
      u_if4.aw_req = 4'b0001;
      u_if4.ar_req = 4'b1000;
      tick();
      chk_w("ares.own", 4'b0001, 0, 1'b1);
      chk_r("ares.rown", 4'b1000, 3, 1'b1);
      u_if4.aw_req = 4'b0000;
      u_if4.ar_req = 4'b0000;
      #3;
      ARESETn = 1'b0;
      #1;
      chk_w("ares.async", 4'b0000, 0, 1'b0);
      chk_r("ares.rasync", 4'b0000, 0, 1'b0);
      #2;
      ARESETn = 1'b1;
      u_if4.aw_req = 4'b1111;
      u_if4.ar_req = 4'b1111;
      tick();
      chk_w("ares.ptr", 4'b0001, 0, 1'b1);
      chk_r("ares.rptr", 4'b0001, 0, 1'b1);
      u_if4.aw_req = 4'b0000;
      u_if4.ar_req = 4'b0000;

      // three masters: 0,1,2,0 with modulo-3 wrap
      u_if3.aw_req = 3'b111;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk($sformatf("m3.g%0d.grant", g), int'(u_if3.w_grant), 1 << (g % 3));
         chk($sformatf("m3.g%0d.id", g), int'(u_if3.w_grant_id), g % 3);
         u_if3.s_BVALID = 1'b1;
         u_if3.s_BREADY = 1'b1;
         tick();
         chk($sformatf("m3.g%0d.done", g), int'(u_if3.w_busy), 0);
         u_if3.s_BVALID = 1'b0;
         u_if3.s_BREADY = 1'b0;
         tick();
      end
      u_if3.aw_req = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
